// File: rtl/dmi_jtag_tap_responder.sv
// JTAG TAP controller and debug transport module, oversampling the JTAG pins on clk_i.
// Completed DMIACCESS scans become DMI requests; responses are returned on the next scan.
module dmi_jtag_tap_responder #(
    parameter logic [31:0] IdcodeValue = 32'h249511C3,
    parameter int unsigned DmiAbits    = 7,
    parameter logic [2:0]  IdleHint    = 3'd1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    input  logic                trst_ni,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    output logic [DmiAbits-1:0] dmi_req_addr_o,
    output logic [1:0]          dmi_req_op_o,
    output logic [31:0]         dmi_req_data_o,
    input  logic                dmi_resp_valid_i,
    output logic                dmi_resp_ready_o,
    input  logic [31:0]         dmi_resp_data_i,
    input  logic                dmi_resp_err_i
);
    localparam int unsigned DmiWidth = DmiAbits + 34;

    localparam logic [4:0] IrIdcode = 5'h01;
    localparam logic [4:0] IrDtmcs  = 5'h10;
    localparam logic [4:0] IrDmi    = 5'h11;

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAUSE_DR, TAP_EX2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAUSE_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_e;

    // ---------------- pin synchronisers ----------------
    logic [1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic       tck_prev;

    // The TCK chain resets high: a spurious fall only reloads TDO, a spurious rise could move the FSM.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_sync  <= 2'b11;
            tck_prev  <= 1'b1;
            tms_sync  <= 2'b11;
            tdi_sync  <= 2'b00;
            trst_sync <= 2'b00;
        end else begin
            tck_sync  <= {tck_sync[0], tck_i};
            tck_prev  <= tck_sync[1];
            tms_sync  <= {tms_sync[0], tms_i};
            tdi_sync  <= {tdi_sync[0], tdi_i};
            trst_sync <= {trst_sync[0], trst_ni};
        end
    end

    logic tck_rise, tck_fall, tms, tdi, tap_reset;
    assign tck_rise  = tck_sync[1] & ~tck_prev;
    assign tck_fall  = ~tck_sync[1] & tck_prev;
    assign tms       = tms_sync[1];
    assign tdi       = tdi_sync[1];
    assign tap_reset = rst_i | ~trst_sync[1];

    // ---------------- TAP state machine ----------------
    tap_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (tap_reset) state_q <= TAP_TLR;
        else           state_q <= state_d;
    end

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TAP_TLR:      state_d = tms ? TAP_TLR    : TAP_RTI;
                TAP_RTI:      state_d = tms ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR:   state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:    state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR:   state_d = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_d = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
                TAP_EX2_DR:   state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_IR:   state_d = tms ? TAP_TLR    : TAP_CAP_IR;
                TAP_CAP_IR:   state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:    state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR:   state_d = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_d = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
                TAP_EX2_IR:   state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
                default:      state_d = TAP_TLR;
            endcase
        end
    end

    // ---------------- instruction register ----------------
    logic [4:0] ir_q, ir_sr;

    always_ff @(posedge clk_i) begin
        if (tap_reset) begin
            ir_q  <= IrIdcode;
            ir_sr <= 5'b00001;
        end else if (state_q == TAP_TLR) begin
            ir_q <= IrIdcode;
        end else if (tck_rise) begin
            case (state_q)
                TAP_CAP_IR: ir_sr <= 5'b00001;
                TAP_SH_IR:  ir_sr <= {tdi, ir_sr[4:1]};
                TAP_UPD_IR: ir_q  <= ir_sr;
                default:    ;
            endcase
        end
    end

    dr_sel_e dr_sel;
    always_comb begin
        case (ir_q)
            IrIdcode: dr_sel = SEL_IDCODE;
            IrDtmcs:  dr_sel = SEL_DTMCS;
            IrDmi:    dr_sel = SEL_DMI;
            default:  dr_sel = SEL_BYPASS;
        endcase
    end

    // ---------------- data registers ----------------
    logic [DmiWidth-1:0] dr_sr, dr_shifted, dr_capture;
    logic [1:0]          dmistat_q;
    logic [31:0]         resp_data_q;
    logic                outstanding_q;
    logic [31:0]         dtmcs_capture;

    assign dtmcs_capture = {14'b0, 2'b0, 1'b0, IdleHint, dmistat_q, 6'(DmiAbits), 4'd1};

    always_comb begin
        case (dr_sel)
            SEL_IDCODE: dr_capture = {{(DmiWidth-32){1'b0}}, IdcodeValue};
            SEL_DTMCS:  dr_capture = {{(DmiWidth-32){1'b0}}, dtmcs_capture};
            SEL_DMI:    dr_capture = {dmi_req_addr_o, resp_data_q, dmistat_q};
            default:    dr_capture = '0;
        endcase
    end

    // Shift right with TDI entering at the MSB of whichever register is selected.
    always_comb begin
        dr_shifted = dr_sr >> 1;
        case (dr_sel)
            SEL_DMI:    dr_shifted[DmiWidth-1] = tdi;
            SEL_BYPASS: dr_shifted[0]          = tdi;
            default:    dr_shifted[31]         = tdi;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dr_sr <= '0;
        end else if (tck_rise && state_q == TAP_CAP_DR) begin
            dr_sr <= dr_capture;
        end else if (tck_rise && state_q == TAP_SH_DR) begin
            dr_sr <= dr_shifted;
        end
    end

    // ---------------- TDO ----------------
    logic ir_side;
    assign ir_side = state_q inside {TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR,
                                     TAP_PAUSE_IR, TAP_EX2_IR, TAP_UPD_IR};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_oe_o <= (state_q == TAP_SH_IR) || (state_q == TAP_SH_DR);
            if (tck_fall) tdo_o <= ir_side ? ir_sr[0] : dr_sr[0];
        end
    end

    // ---------------- DMI request / response ----------------
    logic          upd_dr;
    logic [1:0]    scan_op;
    assign upd_dr  = tck_rise && (state_q == TAP_UPD_DR);
    assign scan_op = dr_sr[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmi_req_valid_o <= 1'b0;
            dmi_req_addr_o  <= '0;
            dmi_req_op_o    <= 2'd0;
            dmi_req_data_o  <= '0;
            outstanding_q   <= 1'b0;
            resp_data_q     <= '0;
            dmistat_q       <= 2'd0;
        end else begin
            if (dmi_req_valid_o && dmi_req_ready_i) begin
                dmi_req_valid_o <= 1'b0;
                outstanding_q   <= 1'b1;
            end
            if (dmi_resp_valid_i && outstanding_q) begin
                outstanding_q <= 1'b0;
                resp_data_q   <= dmi_resp_data_i;
                if (dmi_resp_err_i) dmistat_q <= 2'd2;
            end
            // Any nonzero status is sticky and blocks further DMI updates until cleared.
            if (upd_dr && dr_sel == SEL_DMI && dmistat_q == 2'd0) begin
                if (dmi_req_valid_o || outstanding_q) begin
                    dmistat_q <= 2'd3;
                end else if (scan_op == 2'd1 || scan_op == 2'd2) begin
                    dmi_req_valid_o <= 1'b1;
                    dmi_req_addr_o  <= dr_sr[DmiWidth-1 -: DmiAbits];
                    dmi_req_data_o  <= dr_sr[33:2];
                    dmi_req_op_o    <= scan_op;
                end
            end
            if (upd_dr && dr_sel == SEL_DTMCS) begin
                if (dr_sr[16] || dr_sr[17]) dmistat_q <= 2'd0;
                if (dr_sr[17]) begin
                    dmi_req_valid_o <= 1'b0;
                    outstanding_q   <= 1'b0;
                end
            end
        end
    end

    assign dmi_resp_ready_o = 1'b1;

endmodule

// File: doc/dmi_jtag_tap_responder.md
Name: dmi_jtag_tap_responder

Overview:
- Target-side JTAG TAP and debug transport module (DTM), clocked entirely by the system clock.
- Oversamples the pin-level TCK/TMS/TDI/TRSTn driven by an external JTAG initiator and implements the 16-state TAP controller, a 5-bit IR, and the IDCODE, DTMCS, DMIACCESS and BYPASS data registers.
- Turns completed DMIACCESS scans into debug-module-interface (DMI) requests and returns responses on the next scan.
- Sits between the JTAG pins and the debug module in the test harness.

Parameters:
IdcodeValue, 32'h249511C3, value loaded into IDCODE on Capture-DR; bit 0 must be 1
DmiAbits, 7, DMI address width; also reported in dtmcs.abits
IdleHint, 3'd1, value reported in dtmcs.idle

Ports:
clk_i  in  1  system clock; sole clock of the block
rst_i  in  1  synchronous active-high reset
tck_i  in  1  JTAG TCK, asynchronous to clk_i
tms_i  in  1  JTAG TMS
tdi_i  in  1  JTAG TDI
trst_ni  in  1  JTAG TRSTn, active low, asynchronous
tdo_o  out  1  JTAG TDO data
tdo_oe_o  out  1  TDO driven; high only in Shift-IR and Shift-DR
dmi_req_valid_o  out  1  DMI request valid
dmi_req_ready_i  in  1  DMI request accepted
dmi_req_addr_o  out  DmiAbits  DMI address
dmi_req_op_o  out  2  1 = read, 2 = write
dmi_req_data_o  out  32  DMI write data
dmi_resp_valid_i  in  1  DMI response valid
dmi_resp_ready_o  out  1  response accept; tied to 1
dmi_resp_data_i  in  32  DMI read data
dmi_resp_err_i  in  1  DMI response error

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Synchroniser: tck, tms, tdi and trst_n each pass through a 2-flop synchroniser, then one history flop on tck.
  - TCK rise event = synced tck 0→1; fall event = 1→0.
  - TCK high and low phases are each at least 3 clk_i periods; behaviour is undefined if faster.
- TAP FSM (IEEE 1149.1 states): TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the IR equivalents.
  - Advances only on a rise event, using synced tms.
  - Goes to TLR on rst_i, or on synced trst_n = 0 (checked every clk_i cycle).
  - Five consecutive rise events with tms = 1 reach TLR from any state.
- IR: 5 bits, set to IDCODE (0x01) in TLR.
  - CapIR loads 5'b00001.
  - ShIR shifts LSB-first, with tdi entering at the MSB.
  - UpdIR commits. Any unimplemented code selects BYPASS.
  - Codes: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMIACCESS, 0x1F BYPASS.
- DR shift: on the rise event in ShDR, the selected register shifts right with tdi entering at the MSB. Widths: IDCODE 32, DTMCS 32, DMI 41, BYPASS 1 (captures 0).
- TDO: updated on the fall event to bit 0 of the active shift register. tdo_o and tdo_oe_o reset to 0.
- DTMCS capture value: {14'b0, 2'b0, 1'b0, IdleHint[2:0], dmistat[1:0], abits[5:0]=DmiAbits, version[3:0]=1}.
- DTMCS UpdDR writes:
  - bit 16 (dmireset) clears the sticky error.
  - bit 17 (dmihardreset) clears the sticky error, drops any pending request and discards any outstanding response.
- DMI capture value: {addr, data, status}.
  - status = 0 ok, 2 failed (last response had err = 1), 3 busy (sticky).
  - data = last response data.
- DMI UpdDR handling:
  - Sticky error set: ignored.
  - Request pending or response outstanding: sticky busy is set (dmistat = 3) and the scan is dropped.
  - Otherwise, op 1 or 2 raises dmi_req_valid_o in the next clk_i cycle with addr, op and data from the shift register.
  - op 0 or 3: no request.
- DMI handshake:
  - valid holds with stable payload until valid & ready.
  - After acceptance, the block is "outstanding" until dmi_resp_valid_i.
  - A response is captured in the same cycle it arrives, including the cycle immediately after the request is accepted.
  - A request and response in the same cycle cannot occur; the response is ignored unless outstanding.
- Reset values: FSM TLR, IR 0x01, sticky error 0, pending/outstanding 0, status 0, dmi_req_valid_o 0.
- trst_n low mid-transaction: resets the TAP and IR only; DMI pending/outstanding state is kept.
- rst_i clears everything.

Test Plan:
- rst_i, then five TMS=1 clocks, then CapDR/ShDR 32 bits → TDO LSB-first = 0x249511C3; tdo_oe_o high only during ShDR.
- IR scan 0x10, DR scan 32 bits of 0 → captured 0x00001071; then IR 0x1F, shift 8'hA5 → TDO returns 0 followed by 0xA5 delayed one bit.
- DMI scan addr 0x10, data 0x00000001, op 2 with dmi_req_ready_i held low for 5 cycles → dmi_req_valid_o high with stable payload for 5 cycles, drops the cycle after ready.
- DMI read addr 0x11, response data 0xDEADBEEF err 0 → next DMI scan captures data 0xDEADBEEF, status 0; with err 1 → status 2.
- Second DMI update while a response is outstanding → no new request, next capture status 3, further updates ignored; DTMCS write with bit 16 = 1 → status 0 and requests accepted again.
- trst_ni pulsed low during ShDR of a DMI scan → FSM TLR, IR 0x01, no request issued; rst_i during a pending request → dmi_req_valid_o 0 next cycle.
